// File: rtl/diag_pkg.sv
// diag_pkg: shared state encoding, popcount helper and defaults for the fault localiser
package diag_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPORT = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_RUN_LEN = 3;
  localparam int POP_W = 256;
  function automatic int popcount(input logic [POP_W-1:0] v);
    popcount = 0;
    for (int i = 0; i < POP_W; i++) popcount += int'(v[i]);
  endfunction
endpackage

// File: rtl/diag_run_detect.sv
// diag_run_detect: flags an input vector holding RUN_LEN adjacent ones (no wrap)
module diag_run_detect #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic             out
);
  logic [WIDTH-RUN_LEN:0] win;
  for (genvar i = 0; i <= WIDTH - RUN_LEN; i++) begin : g_win
    assign win[i] = &in_vec[i +: RUN_LEN];
  end
  assign out = |win;
endmodule

// File: rtl/diag_fault_localizer.sv
// diag_fault_localizer: accumulates sticky PE fault map over sweeps, then classifies
// row/column faults and counts faulty PEs
module diag_fault_localizer
  import diag_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int PASSES  = 1,
  parameter int RA_W    = $clog2(ROWS),
  parameter int CNT_W   = $clog2(ROWS * COLS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [COLS-1:0]  in_faults,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [COLS-1:0]  rd_data,
  output logic             busy,
  output logic             done,
  output logic [RA_W-1:0]  row_ptr,
  output logic [ROWS-1:0]  row_fault,
  output logic [COLS-1:0]  col_fault,
  output logic [CNT_W-1:0] fault_count
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int PW = $clog2(PASSES + 1);
  state_t          state;
  logic [COLS-1:0] map [ROWS];
  logic [PW-1:0]   pass_cnt;
  logic [RW-1:0]   col_run [COLS];
  logic [RW-1:0]   col_nxt [COLS];
  logic [COLS-1:0] cur_row;
  logic            row_hit, last_row, kill, clr;
  assign cur_row  = map[row_ptr];
  assign last_row = row_ptr == RA_W'(ROWS - 1);
  assign busy     = state == SCAN || state == REPORT;
  assign done     = state == DONE;
  assign kill     = !rst_n || abort;
  assign clr      = kill || (start && (state == IDLE || state == DONE));
  diag_run_detect #(.WIDTH(COLS), .RUN_LEN(RUN_LEN)) u_row (.in_vec(cur_row), .out(row_hit));
  // Column run counters saturate so a long run cannot overflow the counter
  always_comb
    for (int c = 0; c < COLS; c++)
      col_nxt[c] = !cur_row[c] ? '0 : col_run[c] == RW'(RUN_LEN) ? col_run[c] : col_run[c] + 1'b1;
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < ROWS; r++) map[r] <= '0;
      for (int c = 0; c < COLS; c++) col_run[c] <= '0;
      row_fault   <= '0;
      col_fault   <= '0;
      fault_count <= '0;
      row_ptr     <= '0;
      pass_cnt    <= '0;
      state       <= kill ? IDLE : SCAN;
    end else if (state == SCAN && in_valid) begin
      map[row_ptr] <= cur_row | in_faults;
      row_ptr      <= last_row ? '0 : row_ptr + 1'b1;
      if (last_row) begin
        pass_cnt <= pass_cnt + 1'b1;
        if (pass_cnt == PW'(PASSES - 1)) state <= REPORT;
      end
    end else if (state == REPORT) begin
      for (int c = 0; c < COLS; c++) begin
        col_run[c] <= col_nxt[c];
        if (col_nxt[c] == RW'(RUN_LEN)) col_fault[c] <= 1'b1;
      end
      row_fault[row_ptr] <= row_hit;
      fault_count        <= fault_count + CNT_W'(popcount(POP_W'(cur_row)));
      row_ptr            <= last_row ? '0 : row_ptr + 1'b1;
      if (last_row) state <= DONE;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) rd_data <= '0;
    else rd_data <= ({1'b0, rd_addr} < (RA_W + 1)'(ROWS)) ? map[rd_addr] : '0;
endmodule

// File: tb/tb_diag_fault_localizer.sv
// tb_diag_fault_localizer: directed checks on default, two-pass and 4x16 instances
module tb_diag_fault_localizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, abort, in_valid, s1, s2, s3;
  logic [7:0] f1, f2, rd1, rd2, rf1, rf2, cf1, cf2;
  logic [2:0] a1, a2, ptr1, ptr2;
  logic [6:0] cnt1, cnt2, cnt3;
  logic busy1, busy2, busy3, done1, done2, done3;
  logic [15:0] f3, rd3, cf3;
  logic [1:0] a3, ptr3;
  logic [3:0] rf3;
  logic [7:0] vec [8];
  int n_cmp = 0, n_bad = 0;
  diag_fault_localizer u1 (.clk(clk), .rst_n(rst_n), .start(s1), .abort(abort), .in_valid(in_valid),
    .in_faults(f1), .rd_addr(a1), .rd_data(rd1), .busy(busy1), .done(done1), .row_ptr(ptr1),
    .row_fault(rf1), .col_fault(cf1), .fault_count(cnt1));
  diag_fault_localizer #(.PASSES(2)) u2 (.clk(clk), .rst_n(rst_n), .start(s2), .abort(abort),
    .in_valid(in_valid), .in_faults(f2), .rd_addr(a2), .rd_data(rd2), .busy(busy2), .done(done2),
    .row_ptr(ptr2), .row_fault(rf2), .col_fault(cf2), .fault_count(cnt2));
  diag_fault_localizer #(.ROWS(4), .COLS(16), .RUN_LEN(4)) u3 (.clk(clk), .rst_n(rst_n), .start(s3),
    .abort(abort), .in_valid(in_valid), .in_faults(f3), .rd_addr(a3), .rd_data(rd3), .busy(busy3),
    .done(done3), .row_ptr(ptr3), .row_fault(rf3), .col_fault(cf3), .fault_count(cnt3));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clrvec(input logic [7:0] v);
    for (int i = 0; i < 8; i++) vec[i] = v;
  endtask
  task automatic feed1;
    s1 = 1'b1;
    tick;
    s1 = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      f1 = vec[r];
      tick;
    end
    in_valid = 1'b0;
    f1 = '0;
  endtask
  task automatic wait1;
    for (int k = 0; k < 40 && !done1; k++) tick;
    chk("done1", done1, 1);
  endtask
  initial begin
    rst_n = 0; abort = 0; in_valid = 0; s1 = 0; s2 = 0; s3 = 0;
    f1 = 0; f2 = 0; f3 = 0; a1 = 0; a2 = 0; a3 = 0;
    tick; tick;
    chk("rst_rd", rd1, 0); chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
    chk("rst_ptr", ptr1, 0); chk("rst_rf", rf1, 0); chk("rst_cf", cf1, 0); chk("rst_cnt", cnt1, 0);
    rst_n = 1;
    s1 = 1; in_valid = 1;
    tick;
    chk("lat_busy", busy1, 1);
    s1 = 0;
    repeat (15) tick;
    chk("lat_done16", done1, 0);
    tick;
    chk("lat_done17", done1, 1);
    s1 = 1;
    tick;
    s1 = 0;
    repeat (3) tick;
    in_valid = 0;
    repeat (3) tick;
    in_valid = 1;
    repeat (12) tick;
    chk("gap_done19", done1, 0);
    tick;
    chk("gap_done20", done1, 1);
    in_valid = 0;
    clrvec(8'h00); vec[3] = 8'h04;
    feed1; wait1;
    chk("pe_cnt", cnt1, 1); chk("pe_rf", rf1, 0); chk("pe_cf", cf1, 0);
    a1 = 3;
    tick;
    chk("pe_rd", rd1, 8'h04);
    clrvec(8'h00); vec[5] = 8'h38;
    feed1; wait1;
    chk("row_rf", rf1, 8'h20); chk("row_cnt", cnt1, 3); chk("row_cf", cf1, 0);
    clrvec(8'h00); vec[5] = 8'hAA;
    feed1; wait1;
    chk("alt_rf", rf1, 0); chk("alt_cnt", cnt1, 4);
    clrvec(8'h00); vec[6] = 8'h04; vec[7] = 8'h04; vec[0] = 8'h04;
    feed1; wait1;
    chk("wrap_cf", cf1, 0); chk("wrap_cnt", cnt1, 3);
    clrvec(8'h00); vec[1] = 8'h04; vec[2] = 8'h04; vec[3] = 8'h04;
    feed1; wait1;
    chk("col_cf", cf1, 8'h04); chk("col_rf", rf1, 0);
    clrvec(8'h00); vec[3] = 8'h04;
    feed1;
    repeat (2) tick;
    s1 = 1;
    tick;
    s1 = 0;
    chk("rep_start_busy", busy1, 1);
    repeat (4) tick;
    chk("rep_start_d0", done1, 0);
    tick;
    chk("rep_start_d1", done1, 1); chk("rep_start_cnt", cnt1, 1);
    s1 = 1;
    tick;
    s1 = 0; in_valid = 1; f1 = 8'hFF;
    repeat (3) tick;
    chk("ab_ptr3", ptr1, 3);
    abort = 1; s1 = 1;
    tick;
    abort = 0; s1 = 0; in_valid = 0; f1 = 0;
    chk("ab_busy", busy1, 0); chk("ab_done", done1, 0); chk("ab_ptr", ptr1, 0);
    a1 = 0;
    tick;
    chk("ab_rd", rd1, 0); chk("ab_busy2", busy1, 0); chk("ab_cnt", cnt1, 0);
    clrvec(8'hFF);
    feed1;
    a1 = 2;
    repeat (4) tick;
    chk("mid_cnt", cnt1, 32); chk("mid_rf", rf1, 8'h0F); chk("mid_cf", cf1, 8'hFF); chk("mid_rd", rd1, 8'hFF);
    rst_n = 0;
    tick;
    rst_n = 1;
    chk("mr_rd", rd1, 0); chk("mr_busy", busy1, 0); chk("mr_done", done1, 0); chk("mr_ptr", ptr1, 0);
    chk("mr_rf", rf1, 0); chk("mr_cf", cf1, 0); chk("mr_cnt", cnt1, 0);
    s2 = 1;
    tick;
    s2 = 0; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      f2 = i == 1 ? 8'h01 : i == 9 ? 8'h80 : 8'h00;
      tick;
      if (i == 7) chk("p2_scan", busy2 && !done2 && ptr2 == 0, 1);
    end
    in_valid = 0; f2 = 0;
    for (int k = 0; k < 40 && !done2; k++) tick;
    chk("p2_done", done2, 1); chk("p2_cnt", cnt2, 2);
    a2 = 1;
    tick;
    chk("p2_rd", rd2, 8'h81);
    s3 = 1;
    tick;
    s3 = 0; in_valid = 1; f3 = 16'hFFFF;
    repeat (4) tick;
    in_valid = 0; f3 = 0;
    for (int k = 0; k < 40 && !done3; k++) tick;
    chk("ns_done", done3, 1); chk("ns_rf", rf3, 4'hF); chk("ns_cf", cf3, 16'hFFFF); chk("ns_cnt", cnt3, 64);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/diag_fault_localizer.md
# diag_fault_localizer

Parametrised fault localiser for the systolic array self-test path. It accepts per-row PE fault vectors streamed from the array's test harness over one or more sweeps and ORs them into a sticky ROWS×COLS fault map. It then classifies whole-row and whole-column faults using a configurable run-length rule. It drives the fault map, row/column fault flags and a faulty-PE count to the recovery (remapping) logic.

## Interface
- ROWS, 8, array rows (≥2)
- COLS, 8, array columns (≥2)
- RUN_LEN, 3, consecutive faulty PEs that classify a row/column fault (2 ≤ RUN_LEN ≤ min(ROWS,COLS))
- PASSES, 1, full sweeps accumulated per session (≥1)
- RA_W, $clog2(ROWS), row address width
- CNT_W, $clog2(ROWS*COLS+1), fault count width
- clk  in  1  clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- start  in  1  session start pulse
- abort  in  1  abandon session
- in_valid  in  1  fault beat valid
- in_faults  in  COLS  fault bits for the current row (bit c = column c)
- rd_addr  in  RA_W  fault-map row select
- rd_data  out  COLS  registered fault-map row
- busy  out  1  high in SCAN or REPORT
- done  out  1  high in DONE
- row_ptr  out  RA_W  row the next beat is written to
- row_fault  out  ROWS  row classified faulty
- col_fault  out  COLS  column classified faulty
- fault_count  out  CNT_W  number of set fault-map bits

## Operation
- FSM states: IDLE, SCAN, REPORT, DONE.
- **IDLE/DONE + start:** clear fault map, row_fault, col_fault, fault_count, row_ptr and pass counter, then enter SCAN.
- **SCAN:** each in_valid beat ORs in_faults into map[row_ptr].
  - row_ptr increments and wraps ROWS-1→0; each wrap increments the pass counter.
  - The beat at row_ptr=ROWS-1 of pass PASSES-1 moves the FSM to REPORT.
- **REPORT:** lasts exactly ROWS cycles, visiting rows r=0..ROWS-1 in order.
  - Per-column run counter (saturating at RUN_LEN): incremented if map[r][c]=1, else reset to 0. Any counter reaching RUN_LEN sets col_fault[c], sticky.
  - row_fault[r] is set if map[r] contains RUN_LEN consecutive ones (no wrap across columns).
  - fault_count accumulates popcount(map[r]).
  - Row and column runs do not wrap: row ROWS-1 is not adjacent to row 0.
- **DONE:** outputs are held until the next start.
- **abort (any state):** go to IDLE and clear map, flags, count and pointers. abort has priority over start and over in_valid in the same cycle.
- **Ignored inputs:**
  - start in SCAN/REPORT is ignored.
  - in_valid outside SCAN is ignored.
  - in_valid low in SCAN stalls without changing state.
- **rd_data** is valid in every state; it reflects map[rd_addr] as of the previous cycle. rd_addr ≥ ROWS returns 0.

## Timing
- **Reset (rst_n=0 at a clk edge):**
  - State goes to IDLE.
  - All outputs become 0: rd_data, busy, done, row_ptr, row_fault, col_fault, fault_count.
  - The map is cleared.
  - Reset mid-session discards all progress.
- **start edge:** busy=1 on the next cycle.
- **Session latency:** minimum session is PASSES*ROWS beats plus ROWS REPORT cycles. done rises on the cycle after the last REPORT cycle.
  - Example, defaults with in_valid held high: start at cycle 0, done=1 at cycle 17.
- **Flag timing:** row_fault/col_fault/fault_count update during REPORT and are final only when done=1.
- **rd_data latency:** 1 cycle from rd_addr. A same-cycle write to the addressed row is not visible until the following read.

## Structure
- **Shared package diag_pkg:**
  - state enum {IDLE, SCAN, REPORT, DONE}
  - popcount function
  - default RUN_LEN constant
- **Sub-module diag_run_detect:**
  - Parameters WIDTH and RUN_LEN.
  - Combinational: out=1 if the input vector contains RUN_LEN consecutive ones.
  - Instantiated once for the row check.
  - Column runs use the per-column counters in the top level.

## Test plan
- **Single-PE fault:** defaults; beat 3 carries 8'b0000_0100, all other beats 0.
  - Required: fault_count=1, row_fault=0, col_fault=0.
  - Required: rd_addr=3 gives rd_data=8'h04.
- **Row fault:** row 5 carries 8'b0011_1000 (three adjacent ones).
  - Required: row_fault=8'h20.
  - Control: row 5 = 8'b1010_1010 gives row_fault=0.
- **Column fault with no wrap:** column 2 faulty in rows 6,7,0 (wrap), then in rows 1,2,3.
  - Required: wrap case gives col_fault=0; rows 1–3 case gives col_fault=8'h04.
- **Multi-pass accumulation:** PASSES=2; pass 0 marks row 1 bit 0, pass 1 marks row 1 bit 7.
  - Required: rd_data(row 1)=8'h81, fault_count=2.
- **Control corner cases:**
  - abort together with start mid-SCAN: IDLE, all cleared.
  - start during REPORT: ignored.
  - in_valid gaps: done delayed by exactly the gap count.
  - rst_n low mid-REPORT: all outputs 0 on the next cycle.
- **Non-square array:** ROWS=4, COLS=16, RUN_LEN=4, all beats 16'hFFFF.
  - Required: row_fault=4'hF, col_fault=16'hFFFF, fault_count=64.
